// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op codes, arbiter states and requester ids
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_MUL = 3'd2;
    localparam logic [2:0] ALU_AND = 3'd3;
    localparam logic [2:0] ALU_OR  = 3'd4;
    localparam logic [2:0] ALU_XOR = 3'd5;
    localparam logic [2:0] ALU_SLL = 3'd6;
    localparam logic [2:0] ALU_SLT = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    localparam logic REQ_EXE  = 1'b0;
    localparam logic REQ_ADDR = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-input round-robin grant with last-grant memory
module rr_arbiter2
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    logic last_grant;

    // Contention goes to the requester that did not win last; otherwise pass req through.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = (last_grant == REQ_ADDR) ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= REQ_ADDR;
        end else if (update) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - shares one combinational ALU between execute and address requesters
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [2:0]            req0_ctrl,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [2:0]            req1_ctrl,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,
    output logic [2:0]            alu_ctrl,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    input  logic [DATA_WIDTH-1:0] alu_result,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [DATA_WIDTH-1:0] rsp_result,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  op_count
);

    arb_state_t state, state_next;
    logic [1:0] grant;
    logic       idle;
    logic       accept;
    logic       rsp_hs;
    logic       id_q;

    assign idle       = (state == ST_IDLE);
    assign req0_ready = idle & grant[0];
    assign req1_ready = idle & grant[1];
    assign accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    assign rsp_hs     = rsp_valid & rsp_ready;
    assign busy       = !idle;
    assign rsp_id     = id_q;

    rr_arbiter2 u_rr (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    ({req1_valid, req0_valid}),
        .update (accept),
        .grant  (grant)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept) state_next = ST_EXEC;
            ST_EXEC: state_next = ST_RESP;
            ST_RESP: if (rsp_hs) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Operand registers feed the ALU directly and are left untouched after the op so its inputs stay quiet.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_ctrl   <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            id_q       <= REQ_EXE;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            op_count   <= '0;
        end else begin
            if (accept) begin
                alu_ctrl <= grant[1] ? req1_ctrl : req0_ctrl;
                alu_a    <= grant[1] ? req1_a    : req0_a;
                alu_b    <= grant[1] ? req1_b    : req0_b;
                id_q     <= grant[1];
            end
            if (state == ST_EXEC) begin
                rsp_valid  <= 1'b1;
                rsp_result <= alu_result;
            end else if (rsp_hs) begin
                rsp_valid <= 1'b0;
            end
            if (rsp_hs) begin
                op_count <= op_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule
